// File: rtl/hadamard_fp_pkg.sv
// ============================================================================
// hadamard_fp_pkg : shared sizing constants and rounding helper for the
//                   butterfly mantissa add / normalise path.
// Revision 1.0
// ============================================================================
`default_nettype none

package hadamard_fp_pkg;

   localparam int EXP_W_DEF  = 3;
   localparam int SIG_W_DEF  = 3;
   localparam int LOW_EXP_DEF = 2;

   // Lane width and hidden-bit position for the default configuration.
   localparam int W = SIG_W_DEF + 4 + LOW_EXP_DEF;
   localparam int H = SIG_W_DEF + LOW_EXP_DEF;

   function automatic int float_width(input int exp_w, input int sig_w);
      return 1 + exp_w + sig_w;
   endfunction

   function automatic logic rne_round(input logic keep_lsb, input logic guard,
                                      input logic sticky);
      return guard & (sticky | keep_lsb);
   endfunction

endpackage

`default_nettype wire

// File: rtl/man_add_norm_2_lod.sv
// ============================================================================
// lod_w : leading-one detector returning {zero, position of highest set bit}.
// Revision 1.0
// ============================================================================
`default_nettype none

module lod_w #(
   parameter int WIDTH = 8,
   parameter int PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] value,
   output logic             zero,
   output logic [PW-1:0]    pos
);

   always_comb begin
      zero = ~|value;
      pos  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) pos = PW'(i);
      end
   end

endmodule

`default_nettype wire

// File: rtl/man_add_norm_2.sv
// ============================================================================
// man_add_norm_2 : 3-stage add/sub, normalise, RNE round and pack of two
//                  exponent-aligned mantissa lanes.
// Revision 1.0
// ============================================================================
`default_nettype none

module man_add_norm_2
   import hadamard_fp_pkg::*;
#(
   parameter int EXP_WIDTH  = EXP_W_DEF,
   parameter int SIG_WIDTH  = SIG_W_DEF,
   parameter int LOW_EXPAND = LOW_EXP_DEF
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        valid_in,
   output logic                                        ready_in,
   input  logic [2*(SIG_WIDTH+4+LOW_EXPAND)-1:0]       man_off,
   input  logic [EXP_WIDTH-1:0]                        exp_max,
   input  logic                                        op,
   output logic                                        valid_out,
   input  logic                                        ready_out,
   output logic [float_width(EXP_WIDTH,SIG_WIDTH)-1:0] result
);

   localparam int LW      = SIG_WIDTH + 4 + LOW_EXPAND;
   localparam int MW      = LW - 1;
   localparam int HB      = SIG_WIDTH + LOW_EXPAND;
   localparam int PW      = (MW > 1) ? $clog2(MW) : 1;
   localparam int ES      = EXP_WIDTH + 2;
   localparam int EW      = 2 * MW;
   localparam int FRAC_HI = MW + HB - 1;
   localparam int RB      = MW + LOW_EXPAND - 1;
   localparam int MAX_E   = (1 << EXP_WIDTH) - 1;
   localparam int FW      = float_width(EXP_WIDTH, SIG_WIDTH);

   logic stall;
   assign stall    = valid_out & ~ready_out;
   assign ready_in = ~stall;

   // ---------------- S1: signed magnitude add/sub ----------------
   logic          w_sign0, w_sign1, w_sum_sign;
   logic [MW-1:0] w_mag0, w_mag1, w_sum;

   assign w_sign0 = man_off[LW-1];
   assign w_mag0  = man_off[MW-1:0];
   assign w_sign1 = man_off[2*LW-1] ^ op;
   assign w_mag1  = man_off[LW +: MW];

   always_comb begin
      w_sum      = w_mag0 + w_mag1;
      w_sum_sign = w_sign0;
      if (w_sign0 != w_sign1) begin
         if (w_mag0 >= w_mag1) begin
            w_sum = w_mag0 - w_mag1;
         end else begin
            w_sum      = w_mag1 - w_mag0;
            w_sum_sign = w_sign1;
         end
      end
   end

   logic                 s1_valid, s1_sign;
   logic [MW-1:0]        s1_sum;
   logic [EXP_WIDTH-1:0] s1_exp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_sum   <= '0;
         s1_exp   <= '0;
      end else if (!stall) begin
         s1_valid <= valid_in;
         s1_sign  <= w_sum_sign;
         s1_sum   <= w_sum;
         s1_exp   <= exp_max;
      end
   end

   // ---------------- S2: leading-one detect ----------------
   logic          w_zero;
   logic [PW-1:0] w_pos;

   lod_w #(.WIDTH(MW), .PW(PW)) u_lod (
      .value (s1_sum),
      .zero  (w_zero),
      .pos   (w_pos)
   );

   logic                 s2_valid, s2_sign, s2_zero;
   logic [MW-1:0]        s2_sum;
   logic [EXP_WIDTH-1:0] s2_exp;
   logic [PW-1:0]        s2_pos;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_sign  <= 1'b0;
         s2_zero  <= 1'b1;
         s2_sum   <= '0;
         s2_exp   <= '0;
         s2_pos   <= '0;
      end else if (!stall) begin
         s2_valid <= s1_valid;
         s2_sign  <= s1_sign;
         s2_zero  <= w_zero;
         s2_sum   <= s1_sum;
         s2_exp   <= s1_exp;
         s2_pos   <= w_pos;
      end
   end

   // ---------------- S3: normalise, round, pack ----------------
   // The sum is placed above MW zero bits so right shifts keep every
   // discarded bit available for the sticky reduction.
   logic [ES-1:0]        w_e, w_e_r;
   logic [EW-1:0]        w_ext;
   logic                 w_rnd, w_carry;
   logic [SIG_WIDTH-1:0] w_frac, w_frac_r;
   logic [FW-1:0]        w_packed;
   logic                 w_unused;

   assign w_e = ES'(s2_exp) + ES'(s2_pos) - ES'(HB);

   always_comb begin
      w_ext = {s2_sum, {MW{1'b0}}};
      w_rnd = 1'b0;
      if (s2_pos >= PW'(HB)) begin
         w_ext = w_ext >> (s2_pos - PW'(HB));
         w_rnd = rne_round(w_ext[RB+1], w_ext[RB], |w_ext[RB-1:0]);
      end else begin
         w_ext = w_ext << (PW'(HB) - s2_pos);
      end
   end

   assign w_frac              = w_ext[FRAC_HI -: SIG_WIDTH];
   assign {w_carry, w_frac_r} = {1'b0, w_frac} + (SIG_WIDTH+1)'(w_rnd);
   assign w_e_r               = w_e + ES'(w_carry);
   assign w_unused            = &{1'b0, w_ext[EW-1:FRAC_HI+1]};

   always_comb begin
      if (s2_zero || w_e[ES-1] || (w_e == '0)) begin
         w_packed = '0;
      end else if (w_e_r > ES'(MAX_E)) begin
         w_packed = {s2_sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b1}}};
      end else begin
         w_packed = {s2_sign, w_e_r[EXP_WIDTH-1:0], w_frac_r};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out <= 1'b0;
         result    <= '0;
      end else if (!stall) begin
         valid_out <= s2_valid;
         result    <= w_packed;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_man_add_norm_2.sv
// ============================================================================
// tb_man_add_norm_2 : scoreboard bench with arithmetic reference model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_man_add_norm_2;
   import hadamard_fp_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic        ready_in;
   logic [17:0] man_off;
   logic [2:0]  exp_max;
   logic        op;
   logic        valid_out;
   logic        ready_out;
   logic [6:0]  result;

   man_add_norm_2 dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .man_off   (man_off),
      .exp_max   (exp_max),
      .op        (op),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .result    (result)
   );

   always #5 clk = ~clk;

   int         n_cmp  = 0;
   int         n_fail = 0;
   logic [6:0] exp_q[$];
   logic       held = 1'b0;
   logic [6:0] held_val;
   bit         rand_done;

   // Reference: signed integer arithmetic on the lane values, then
   // normalise to 1.fff with round-half-even on the exact remainder.
   function automatic logic [6:0] model(input int m0, input int s0, input int m1,
                                        input int s1, input int e, input int opv);
      int a, b, r, mag, p, q, rem, half, ex;
      logic sg;
      a   = (s0 != 0) ? -m0 : m0;
      b   = ((s1 ^ opv) != 0) ? -m1 : m1;
      r   = a + b;
      sg  = (r < 0);
      mag = sg ? -r : r;
      if (mag == 0) return 7'd0;
      p = 0;
      for (int i = 0; i < W - 1; i++) if (mag >= (1 << i)) p = i;
      ex = e + p - H;
      if (ex <= 0) return 7'd0;
      if (p >= H) begin
         q    = mag >> (p - 3);
         rem  = mag % (1 << (p - 3));
         half = 1 << (p - 4);
         if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      end else begin
         q = (mag << (H - p)) >> (H - 3);
      end
      if (q == 16) begin
         q  = 8;
         ex = ex + 1;
      end
      if (ex > 7) return {sg, 3'b111, 3'b111};
      return {sg, ex[2:0], q[2:0]};
   endfunction

   task automatic send(input int m0, input int s0, input int m1, input int s1,
                       input int e, input int opv);
      logic [7:0] a8, b8;
      int         waited;
      a8 = m0[7:0];
      b8 = m1[7:0];
      @(posedge clk);
      #1;
      valid_in = 1'b1;
      man_off  = {s1[0], b8, s0[0], a8};
      exp_max  = e[2:0];
      op       = opv[0];
      waited   = 0;
      forever begin
         @(negedge clk);
         if (ready_in) begin
            exp_q.push_back(model(m0, s0, m1, s1, e, opv));
            break;
         end
         waited++;
         if (waited > 100) begin
            n_fail++;
            $display("FAIL send_timeout: ready_in stuck at %0b, required 1", ready_in);
            break;
         end
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   // Monitor: ready_in relation, stall stability, scoreboard pop.
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else begin
         n_cmp++;
         if (ready_in !== ~(valid_out & ~ready_out)) begin
            n_fail++;
            $display("FAIL ready_in: got %b, required %b", ready_in, ~(valid_out & ~ready_out));
         end
         if (held) begin
            n_cmp++;
            if (valid_out !== 1'b1 || result !== held_val) begin
               n_fail++;
               $display("FAIL stall_hold: got v=%b r=%b, required v=1 r=%b",
                        valid_out, result, held_val);
            end
         end
         if (valid_out && ready_out) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_out: got %b, required no output", result);
            end else begin
               logic [6:0] ev;
               ev = exp_q.pop_front();
               if (result !== ev) begin
                  n_fail++;
                  $display("FAIL result: got %b, required %b", result, ev);
               end
            end
         end
         held     = valid_out & ~ready_out;
         held_val = result;
      end
   end

   initial begin
      rst       = 1'b1;
      valid_in  = 1'b0;
      man_off   = '0;
      exp_max   = '0;
      op        = 1'b0;
      ready_out = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp += 3;
      if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", valid_out); end
      if (result !== 7'd0)    begin n_fail++; $display("FAIL reset_result: got %b, required 0", result); end
      if (ready_in !== 1'b1)  begin n_fail++; $display("FAIL reset_ready: got %b, required 1", ready_in); end
      rst = 1'b0;

      // Directed cases
      send(8'h28, 0, 8'h14, 0, 3, 0);
      send(8'h28, 0, 8'h28, 0, 3, 1);
      send(8'h24, 0, 8'h20, 0, 3, 0);
      send(8'h2C, 0, 8'h20, 0, 3, 0);
      send(8'h3C, 0, 8'h3C, 0, 7, 0);
      send(8'h24, 0, 8'h20, 0, 1, 1);
      send(8'h20, 0, 8'h30, 0, 4, 1);
      send(8'h28, 1, 8'h14, 1, 5, 0);
      idle();
      repeat (5) @(posedge clk);

      // Backpressure: six beats, ready_out low for four cycles mid-stream
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(8'h20 + 4 * i, i % 2, 8'h10 + i, 0, 2 + i, i % 2);
            idle();
         end
         begin
            repeat (3) @(posedge clk);
            #1 ready_out = 1'b0;
            repeat (4) @(posedge clk);
            #1 ready_out = 1'b1;
         end
      join
      repeat (8) @(posedge clk);

      // Randomised stream with random backpressure
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               send($urandom_range(0, 63), $urandom_range(0, 1), $urandom_range(0, 63),
                    $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1));
               if ($urandom_range(0, 4) == 0) idle();
            end
            idle();
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 ready_out = ($urandom_range(0, 3) != 0);
            end
            ready_out = 1'b1;
         end
      join

      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, required 0", exp_q.size());
      end

      // Reset with three beats in flight
      send(8'h28, 0, 8'h14, 0, 3, 0);
      send(8'h2C, 0, 8'h20, 0, 3, 0);
      send(8'h24, 0, 8'h20, 0, 3, 0);
      @(posedge clk);
      #2;
      valid_in = 1'b0;
      rst      = 1'b1;
      #1;
      n_cmp += 2;
      if (valid_out !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b, required 0", valid_out); end
      if (result !== 7'd0)    begin n_fail++; $display("FAIL async_rst_result: got %b, required 0", result); end
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (8) @(posedge clk);

      // Post-reset sanity beat
      send(8'h3C, 0, 8'h3C, 0, 7, 0);
      idle();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL final_drain: got %0d pending, required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
